de3cd_ads8556_reader: RTL and testbench
=======================================

# de3cd_ads8556_reader

Frame-gated ADS8556 conversion and readout controller, the consumer of `ads8556_syncn`. Once `ads8556_syncn` goes low, the block starts one conversion on each pixel tick. It drives CONVST, waits on BUSY, then reads NCH 16-bit channel words over the parallel CS/RD bus. Samples are emitted as a valid-only stream toward the DAQ FIFO. A frame ends after PIX_NUM pixels.

## Interface
Parameters:
- `NCH`, 2: channels read per conversion, 1..6.
- `PIX_NUM`, 3694: pixels (conversions) per frame.
- `CONVST_W`, 4: CONVST high width, clk cycles, ≥1.
- `RD_W`, 3: RD low width, clk cycles, ≥2.
- `RD_H`, 2: RD high gap between words, clk cycles, ≥1.
- `BUSY_TO`, 255: BUSY watchdog limit, clk cycles.

Ports:
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset, synchronous, active-low. Clock is `clk`.
- `ads8556_syncn`, in, 1: frame gate, active low, clk-synchronous.
- `pix_tick`, in, 1: one-cycle pixel/conversion strobe.
- `adc_busy`, in, 1: ADC BUSY, asynchronous.
- `adc_db`, in, 16: ADC parallel data bus.
- `adc_convst`, out, 1: conversion start.
- `adc_csn`, out, 1: chip select, active low.
- `adc_rdn`, out, 1: read strobe, active low.
- `m_data`, out, 16: sample word.
- `m_chan`, out, 3: channel index 0..NCH-1.
- `m_valid`, out, 1: one-cycle sample strobe.
- `m_last`, out, 1: with `m_valid`, marks last channel of last pixel.
- `frame_done`, out, 1: one-cycle pulse when the frame completes.
- `overrun`, out, 1: sticky error; cleared by reset or by a new frame arm.
- `busy_err`, out, 1: sticky error; cleared by reset or by a new frame arm.

## Operation
- `adc_busy` passes through a 2-FF synchronizer. All BUSY decisions use the synchronized value.
- FSM states and transitions:
  - IDLE → ARMED on a falling edge of `ads8556_syncn` (registered previous value is 1, current is 0). On this edge `overrun` and `busy_err` clear, and the pixel counter is set to 0.
  - ARMED → CONV on `pix_tick` while `ads8556_syncn` = 0. If `ads8556_syncn` = 1 while in ARMED, go to IDLE with no `frame_done`.
  - CONV: `adc_convst` = 1 for CONVST_W cycles, then → WBH.
  - WBH: wait for BUSY = 1, then → WBL.
  - WBL: wait for BUSY = 0, then → RDL with channel counter = 0.
  - WBH and WBL share one watchdog counter. If it reaches BUSY_TO: set `busy_err`, release the bus, → IDLE.
  - RDL: `adc_csn` = 0, `adc_rdn` = 0 for RD_W cycles. On the last cycle `adc_db` is registered into `m_data`. `m_valid` = 1 on the following cycle, together with `m_chan` = channel counter. → RDH.
  - RDH: `adc_rdn` = 1, `adc_csn` stays 0, for RD_H cycles. Then:
    - if more channels remain: channel counter + 1, → RDL;
    - otherwise: `adc_csn` = 1, pixel counter + 1, → PIXEND.
  - PIXEND:
    - if pixel counter = PIX_NUM: pulse `frame_done`, → IDLE;
    - else if `ads8556_syncn` = 1: → IDLE, no `frame_done` (frame aborted);
    - else → ARMED.
- `m_last` = 1 only with the `m_valid` for channel NCH-1 of pixel PIX_NUM-1.
- A `pix_tick` that arrives in any state other than ARMED or IDLE sets `overrun`. That tick is dropped, never queued.
- A `pix_tick` and an `ads8556_syncn` falling edge in the same cycle: the block arms only. That tick does not start a conversion.
- The pixel counter is 12 bits and saturates at PIX_NUM; it never wraps. The channel counter is 3 bits.
- A new `ads8556_syncn` falling edge while a frame is running is ignored. Rearm happens only from IDLE.
- Reset, including reset in the middle of a read, forces all outputs to their idle values on the next edge and the FSM to IDLE.

## Timing
- Reset/idle output values: `adc_convst` 0, `adc_csn` 1, `adc_rdn` 1, `m_data` 0, `m_chan` 0, `m_valid` 0, `m_last` 0, `frame_done` 0, `overrun` 0, `busy_err` 0.
- `adc_convst` rises 1 cycle after an accepted `pix_tick`. This latency is registered.
- BUSY response latency is 2 cycles, from the synchronizer.
- Per-pixel read time = NCH·(RD_W+RD_H) + 1 cycles after BUSY falls.
- Minimum `pix_tick` spacing = 1 + CONVST_W + conversion time + 4 + read time. Closer ticks produce `overrun`.
- `frame_done` occurs 1 cycle after the final RDH cycle. The last pixel's final `m_valid` precedes it.

## Structure
- Package `de3cd_daq_pkg` holds:
  - the FSM state enum (IDLE, ARMED, CONV, WBH, WBL, RDL, RDH, PIXEND);
  - the constants ADS8556_DW=16 and ADS8556_MAX_CH=6.
- Sub-module `de3cd_bit_sync`: a 2-FF synchronizer with reset value 0, used for `adc_busy`.
- All other logic stays in one FSM plus its counters.

## Test plan
All scenarios use NCH=2, PIX_NUM=4, CONVST_W=4, RD_W=3, RD_H=2 unless stated.
- Nominal frame: `ads8556_syncn` falls, then 4 `pix_tick`s 100 cycles apart. The BUSY model holds high for 20 cycles, and `adc_db` = 0x1000 + pixel·16 + chan. Required: 8 `m_valid` with matching data and `m_chan` 0,1,0,1…; `m_last` only on the 8th; one `frame_done`; CONVST width exactly 4.
- Overrun: second `pix_tick` 10 cycles after the first, during WBL. Required: `overrun` = 1; the pixel still completes with 2 words; the dropped tick is not counted.
- BUSY stuck low, BUSY_TO=50. Required: `busy_err` set 52 cycles after CONVST falls; `adc_csn` = `adc_rdn` = 1; FSM back in IDLE; no `m_valid`.
- Abort: `ads8556_syncn` rises after pixel 1 CONV starts. Required: pixel 1 fully read (2 words), then IDLE, no `frame_done`; the next falling edge rearms and clears the flags.
- Reset mid-RDL. Required: the next cycle shows `adc_csn` = 1, `adc_rdn` = 1, `m_valid` = 0, FSM in IDLE; the following frame is nominal.
- Simultaneous tick and arm: `pix_tick` coincides with the `ads8556_syncn` falling edge. Required: no CONVST; the next tick converts.

Source files
------------

// File: rtl/de3cd_daq_pkg.sv
// Purpose : shared types and constants for the DE3CD DAQ front end.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package de3cd_daq_pkg;

    localparam int ADS8556_DW     = 16;
    localparam int ADS8556_MAX_CH = 6;

    // Reader FSM states, in the order a normal pixel walks through them.
    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        CONV,
        WBH,
        WBL,
        RDL,
        RDH,
        PIXEND
    } rd_state_e;

endpackage

// File: rtl/de3cd_bit_sync.sv
// Purpose : 2-FF synchronizer for a single asynchronous level, reset value 0.
// Latency : 2 clk cycles from d to q.
// Backpressure: none; the level is always sampled.
// Ports   : clk, rst_n (sync, active-low), d (async in), q (synchronized out).
module de3cd_bit_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/de3cd_ads8556_reader.sv
// Purpose : frame-gated ADS8556 convert/readout; one conversion per pixel tick, NCH words per pixel.
// Latency : CONVST rises 1 cycle after an accepted tick; each word leaves 1 cycle after its RD strobe ends.
// Backpressure: none; output is valid-only, ticks arriving while busy are dropped and flag overrun.
// Ports   : clk/rst_n (sync, active-low); ads8556_syncn frame gate; pix_tick strobe;
//           adc_busy/adc_db from the ADC; adc_convst/adc_csn/adc_rdn to the ADC;
//           m_data/m_chan/m_valid/m_last sample stream; frame_done pulse; overrun/busy_err sticky flags.
module de3cd_ads8556_reader
    import de3cd_daq_pkg::*;
#(
    parameter int NCH      = 2,
    parameter int PIX_NUM  = 3694,
    parameter int CONVST_W = 4,
    parameter int RD_W     = 3,
    parameter int RD_H     = 2,
    parameter int BUSY_TO  = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ads8556_syncn,
    input  logic                  pix_tick,
    input  logic                  adc_busy,
    input  logic [ADS8556_DW-1:0] adc_db,
    output logic                  adc_convst,
    output logic                  adc_csn,
    output logic                  adc_rdn,
    output logic [ADS8556_DW-1:0] m_data,
    output logic [2:0]            m_chan,
    output logic                  m_valid,
    output logic                  m_last,
    output logic                  frame_done,
    output logic                  overrun,
    output logic                  busy_err
);

    localparam int WD_W = $clog2(BUSY_TO + 2);

    localparam logic [7:0]      CONVST_LAST = 8'(CONVST_W - 1);
    localparam logic [7:0]      RDW_LAST    = 8'(RD_W - 1);
    localparam logic [7:0]      RDH_LAST    = 8'(RD_H - 1);
    localparam logic [2:0]      CH_LAST     = 3'(NCH - 1);
    localparam logic [11:0]     PIX_END     = 12'(PIX_NUM);
    localparam logic [11:0]     PIX_LAST    = 12'(PIX_NUM - 1);
    localparam logic [WD_W-1:0] WD_LIM      = WD_W'(BUSY_TO);

    logic busy_s;

    rd_state_e state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;       // phase width counter (CONV/RDL/RDH)
    logic [WD_W-1:0]       wd_q, wd_d;         // BUSY watchdog, shared by WBH and WBL
    logic                  wd_hit_q, wd_hit_d;
    logic [2:0]            ch_q, ch_d;
    logic [11:0]           pix_q, pix_d;
    logic                  sync_prev_q, sync_prev_d;
    logic                  convst_q, convst_d;
    logic                  csn_q, csn_d;
    logic                  rdn_q, rdn_d;
    logic [ADS8556_DW-1:0] data_q, data_d;
    logic [2:0]            chan_q, chan_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic                  fdone_q, fdone_d;
    logic                  overrun_q, overrun_d;
    logic                  berr_q, berr_d;
    logic                  in_wait;

    de3cd_bit_sync u_busy_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (adc_busy),
        .q     (busy_s)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ch_d        = ch_q;
        pix_d       = pix_q;
        sync_prev_d = ads8556_syncn;
        data_d      = data_q;
        chan_d      = chan_q;
        valid_d     = 1'b0;
        last_d      = 1'b0;
        fdone_d     = 1'b0;
        overrun_d   = overrun_q;
        berr_d      = berr_q;

        in_wait  = (state_q == WBH) || (state_q == WBL);
        // Saturating watchdog; the limit compare is registered so the
        // wide comparator stays out of the next-state path.
        wd_d     = '0;
        if (in_wait) begin
            wd_d = (wd_q == WD_LIM) ? wd_q : wd_q + WD_W'(1);
        end
        wd_hit_d = in_wait && (wd_q == WD_LIM);

        // Ticks are only meaningful while waiting; anywhere else they are dropped.
        if (pix_tick && (state_q != IDLE) && (state_q != ARMED)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                // Arming wins over a coincident tick: the tick is simply ignored here.
                if (sync_prev_q && !ads8556_syncn) begin
                    state_d   = ARMED;
                    overrun_d = 1'b0;
                    berr_d    = 1'b0;
                    pix_d     = '0;
                end
            end
            ARMED: begin
                if (ads8556_syncn) begin
                    state_d = IDLE;
                end else if (pix_tick) begin
                    state_d = CONV;
                    cnt_d   = '0;
                end
            end
            CONV: begin
                if (cnt_q == CONVST_LAST) begin
                    state_d = WBH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WBH: begin
                if (wd_hit_q) begin
                    state_d = IDLE;
                    berr_d  = 1'b1;
                end else if (busy_s) begin
                    state_d = WBL;
                end
            end
            WBL: begin
                if (wd_hit_q) begin
                    state_d = IDLE;
                    berr_d  = 1'b1;
                end else if (!busy_s) begin
                    state_d = RDL;
                    ch_d    = '0;
                    cnt_d   = '0;
                end
            end
            RDL: begin
                if (cnt_q == RDW_LAST) begin
                    data_d  = adc_db;
                    chan_d  = ch_q;
                    valid_d = 1'b1;
                    last_d  = (ch_q == CH_LAST) && (pix_q == PIX_LAST);
                    state_d = RDH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RDH: begin
                if (cnt_q == RDH_LAST) begin
                    cnt_d = '0;
                    if (ch_q != CH_LAST) begin
                        ch_d    = ch_q + 3'd1;
                        state_d = RDL;
                    end else begin
                        pix_d   = (pix_q == PIX_END) ? pix_q : pix_q + 12'd1;
                        // Raised on entry to PIXEND so it appears right after the last RDH cycle.
                        fdone_d = (pix_q == PIX_LAST);
                        state_d = PIXEND;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            PIXEND: begin
                if (pix_q == PIX_END) begin
                    state_d = IDLE;
                end else if (ads8556_syncn) begin
                    state_d = IDLE;
                end else begin
                    state_d = ARMED;
                end
            end
            default: state_d = IDLE;
        endcase

        // Bus strobes are registered from the next state so they are glitch-free.
        convst_d = (state_d == CONV);
        csn_d    = !((state_d == RDL) || (state_d == RDH));
        rdn_d    = !(state_d == RDL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wd_q        <= '0;
            wd_hit_q    <= 1'b0;
            ch_q        <= '0;
            pix_q       <= '0;
            sync_prev_q <= 1'b0;    // a gate already low at reset must not arm
            convst_q    <= 1'b0;
            csn_q       <= 1'b1;
            rdn_q       <= 1'b1;
            data_q      <= '0;
            chan_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            fdone_q     <= 1'b0;
            overrun_q   <= 1'b0;
            berr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wd_q        <= wd_d;
            wd_hit_q    <= wd_hit_d;
            ch_q        <= ch_d;
            pix_q       <= pix_d;
            sync_prev_q <= sync_prev_d;
            convst_q    <= convst_d;
            csn_q       <= csn_d;
            rdn_q       <= rdn_d;
            data_q      <= data_d;
            chan_q      <= chan_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            fdone_q     <= fdone_d;
            overrun_q   <= overrun_d;
            berr_q      <= berr_d;
        end
    end

    assign adc_convst = convst_q;
    assign adc_csn    = csn_q;
    assign adc_rdn    = rdn_q;
    assign m_data     = data_q;
    assign m_chan     = chan_q;
    assign m_valid    = valid_q;
    assign m_last     = last_q;
    assign frame_done = fdone_q;
    assign overrun    = overrun_q;
    assign busy_err   = berr_q;

endmodule

// File: tb/tb_de3cd_ads8556_reader.sv
// Purpose : directed self-checking bench for de3cd_ads8556_reader (NCH=2, PIX_NUM=4, BUSY_TO=50).
// Latency : n/a.
// Backpressure: n/a.
module tb_de3cd_ads8556_reader;
    import de3cd_daq_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        syncn;
    logic        pix_tick;
    logic        adc_busy;
    logic [15:0] adc_db;
    logic        adc_convst, adc_csn, adc_rdn;
    logic [15:0] m_data;
    logic [2:0]  m_chan;
    logic        m_valid, m_last, frame_done, overrun, busy_err;

    int checks = 0;
    int errors = 0;

    bit busy_stuck = 1'b0;
    int rd_total   = 0;
    int rd_base    = 0;

    // Monitor state (written only by the negedge monitor).
    logic [15:0] cap_data [0:63];
    logic [2:0]  cap_chan [0:63];
    logic        cap_last [0:63];
    int   n_cap = 0, fd_total = 0, conv_run = 0, conv_w_last = 0, conv_total = 0;
    int   cyc_n = 0, cyc_conv_fall = 0, cyc_be = 0;
    logic conv_prev = 1'b0, be_prev = 1'b0;

    de3cd_ads8556_reader #(
        .NCH(2), .PIX_NUM(4), .CONVST_W(4), .RD_W(3), .RD_H(2), .BUSY_TO(50)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ads8556_syncn(syncn), .pix_tick(pix_tick),
        .adc_busy(adc_busy), .adc_db(adc_db), .adc_convst(adc_convst),
        .adc_csn(adc_csn), .adc_rdn(adc_rdn), .m_data(m_data), .m_chan(m_chan),
        .m_valid(m_valid), .m_last(m_last), .frame_done(frame_done),
        .overrun(overrun), .busy_err(busy_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ADC data model: word k of the frame = 0x1000 + pixel*16 + chan.
    assign adc_db = 16'(32'h1000 + ((rd_total - rd_base) / 2) * 16 + ((rd_total - rd_base) % 2));

    // BUSY model: rises 2 cycles after CONVST falls, stays high 20 cycles.
    initial begin
        adc_busy = 1'b0;
        wait (rst_n === 1'b1);
        forever begin
            @(negedge adc_convst);
            if (!busy_stuck) begin
                repeat (2) @(posedge clk);
                #1 adc_busy = 1'b1;
                repeat (20) @(posedge clk);
                #1 adc_busy = 1'b0;
            end
        end
    end

    // Each completed RD strobe advances the data model to the next word.
    initial begin
        wait (rst_n === 1'b1);
        forever begin
            @(posedge adc_rdn);
            rd_total++;
        end
    end

    always @(negedge clk) begin
        cyc_n     <= cyc_n + 1;
        conv_prev <= adc_convst;
        be_prev   <= busy_err;
        if (m_valid === 1'b1) begin
            cap_data[n_cap % 64] <= m_data;
            cap_chan[n_cap % 64] <= m_chan;
            cap_last[n_cap % 64] <= m_last;
            n_cap <= n_cap + 1;
        end
        if (frame_done === 1'b1) fd_total <= fd_total + 1;
        if (adc_convst === 1'b1) begin
            conv_run <= conv_run + 1;
        end else if (conv_run != 0) begin
            conv_w_last <= conv_run;
            conv_run    <= 0;
            conv_total  <= conv_total + 1;
        end
        if (conv_prev === 1'b1 && adc_convst === 1'b0) cyc_conv_fall <= cyc_n;
        if (be_prev === 1'b0 && busy_err === 1'b1) cyc_be <= cyc_n;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick;
        pix_tick = 1'b1;
        cyc(1);
        pix_tick = 1'b0;
    endtask

    function automatic logic [15:0] exp_word(input int i);
        return 16'(32'h1000 + (i / 2) * 16 + (i % 2));
    endfunction

    // Words captured since cb: data, channel and last flag against the frame model.
    task automatic chk_words(input string tag, input int cb, input int n);
        chk({tag, "_count"}, 32'(n_cap - cb), 32'(n));
        for (int i = 0; i < n; i++) begin
            chk({tag, "_data"}, 32'(cap_data[(cb + i) % 64]), 32'(exp_word(i)));
            chk({tag, "_chan"}, 32'(cap_chan[(cb + i) % 64]), 32'(i % 2));
            chk({tag, "_last"}, 32'(cap_last[(cb + i) % 64]), 32'(i == 7));
        end
    endtask

    initial begin
        int  cb, fd0, cv0, k;
        bit  found;

        rst_n = 1'b0; syncn = 1'b1; pix_tick = 1'b0;
        cyc(3);
        chk("rst_convst", 32'(adc_convst), 0);
        chk("rst_csn",    32'(adc_csn),    1);
        chk("rst_rdn",    32'(adc_rdn),    1);
        chk("rst_mdata",  32'(m_data),     0);
        chk("rst_mchan",  32'(m_chan),     0);
        chk("rst_mvalid", 32'(m_valid),    0);
        chk("rst_mlast",  32'(m_last),     0);
        chk("rst_fdone",  32'(frame_done), 0);
        chk("rst_overrun",32'(overrun),    0);
        chk("rst_busyerr",32'(busy_err),   0);
        rst_n = 1'b1;
        cyc(3);

        // Nominal frame: 4 ticks 100 cycles apart.
        rd_base = rd_total; cb = n_cap; fd0 = fd_total; cv0 = conv_total;
        syncn = 1'b0;
        cyc(3);
        chk("nom_armed", 32'(dut.state_q), 32'(ARMED));
        pix_tick = 1'b1;
        chk("nom_convst_pre", 32'(adc_convst), 0);
        cyc(1);
        pix_tick = 1'b0;
        chk("nom_convst_rise", 32'(adc_convst), 1);
        cyc(99);
        for (int p = 1; p < 4; p++) begin
            pulse_tick();
            cyc(99);
        end
        chk_words("nom", cb, 8);
        chk("nom_fdone", 32'(fd_total - fd0), 1);
        chk("nom_convst_w", 32'(conv_w_last), 4);
        chk("nom_convs", 32'(conv_total - cv0), 4);
        chk("nom_overrun", 32'(overrun), 0);
        chk("nom_busyerr", 32'(busy_err), 0);
        chk("nom_idle", 32'(dut.state_q), 32'(IDLE));

        // Overrun: second tick 10 cycles after the first lands in WBL.
        syncn = 1'b1;
        cyc(3);
        rd_base = rd_total; cb = n_cap; fd0 = fd_total;
        syncn = 1'b0;
        cyc(3);
        pulse_tick();
        cyc(9);
        chk("ovr_in_wbl", 32'(dut.state_q), 32'(WBL));
        pulse_tick();
        chk("ovr_flag", 32'(overrun), 1);
        cyc(50);
        chk("ovr_pix0_words", 32'(n_cap - cb), 2);
        for (int p = 1; p < 4; p++) begin
            pulse_tick();
            cyc(59);
        end
        cyc(10);
        chk_words("ovr", cb, 8);
        chk("ovr_fdone", 32'(fd_total - fd0), 1);
        chk("ovr_sticky", 32'(overrun), 1);

        // BUSY stuck low: watchdog fires.
        busy_stuck = 1'b1;
        syncn = 1'b1;
        cyc(3);
        cb = n_cap;
        syncn = 1'b0;
        cyc(3);
        chk("stk_overrun_clr", 32'(overrun), 0);
        pulse_tick();
        cyc(80);
        chk("stk_busyerr", 32'(busy_err), 1);
        chk("stk_delay", 32'(cyc_be - cyc_conv_fall), 52);
        chk("stk_csn", 32'(adc_csn), 1);
        chk("stk_rdn", 32'(adc_rdn), 1);
        chk("stk_idle", 32'(dut.state_q), 32'(IDLE));
        chk("stk_novalid", 32'(n_cap - cb), 0);
        busy_stuck = 1'b0;

        // Abort: gate rises while pixel 1 is converting.
        syncn = 1'b1;
        cyc(3);
        rd_base = rd_total; cb = n_cap; fd0 = fd_total;
        syncn = 1'b0;
        cyc(3);
        chk("abt_busyerr_clr", 32'(busy_err), 0);
        pulse_tick();
        cyc(59);
        pulse_tick();
        cyc(2);
        chk("abt_in_conv", 32'(adc_convst), 1);
        syncn = 1'b1;
        cyc(60);
        chk_words("abt", cb, 4);
        chk("abt_nofdone", 32'(fd_total - fd0), 0);
        chk("abt_idle", 32'(dut.state_q), 32'(IDLE));

        // Reset in the middle of an RD low phase.
        syncn = 1'b0;
        cyc(3);
        pulse_tick();
        found = 1'b0;
        k = 0;
        while (!found && k < 100) begin
            if (adc_rdn === 1'b0) found = 1'b1;
            else begin
                cyc(1);
                k++;
            end
        end
        chk("rst_rdl_reached", 32'(found), 1);
        rst_n = 1'b0;
        cyc(1);
        chk("mrst_csn", 32'(adc_csn), 1);
        chk("mrst_rdn", 32'(adc_rdn), 1);
        chk("mrst_mvalid", 32'(m_valid), 0);
        chk("mrst_idle", 32'(dut.state_q), 32'(IDLE));
        syncn = 1'b1;
        cyc(2);
        rst_n = 1'b1;
        cyc(3);
        rd_base = rd_total; cb = n_cap; fd0 = fd_total;
        syncn = 1'b0;
        cyc(3);
        for (int p = 0; p < 4; p++) begin
            pulse_tick();
            cyc(59);
        end
        cyc(10);
        chk_words("post", cb, 8);
        chk("post_fdone", 32'(fd_total - fd0), 1);

        // Tick coincident with the arming edge: arm only.
        syncn = 1'b1;
        cyc(3);
        rd_base = rd_total; cb = n_cap; fd0 = fd_total; cv0 = conv_total;
        syncn = 1'b0;
        pix_tick = 1'b1;
        cyc(1);
        pix_tick = 1'b0;
        cyc(10);
        chk("sim_noconv", 32'(conv_total - cv0), 0);
        chk("sim_armed", 32'(dut.state_q), 32'(ARMED));
        chk("sim_overrun", 32'(overrun), 0);
        pulse_tick();
        cyc(2);
        chk("sim_convst", 32'(adc_convst), 1);
        cyc(55);
        chk_words("sim", cb, 2);
        syncn = 1'b1;
        cyc(3);
        chk("sim_idle", 32'(dut.state_q), 32'(IDLE));
        chk("sim_nofdone", 32'(fd_total - fd0), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
